// File: rtl/alu_seq_if.sv
// Operation-issue / result-consume bus for alu_seq.
//
// Handshake rules (both channels):
//  - A transfer happens on a rising edge where valid && ready are both high.
//  - A source holds valid and its payload stable until the transfer happens.
//  - The input side may see ready fall without a transfer while the divider runs.
//  - The output side holds result/flags stable while out_valid && !out_ready.
interface alu_seq_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_out;
  logic             exception;
  logic             error;

  // Requester/consumer side.
  modport master (
    output in_valid, a_in, b_in, opcode, out_ready,
    input  in_ready, out_valid, result_out, exception, error
  );

  // ALU side.
  modport slave (
    input  in_valid, a_in, b_in, opcode, out_ready,
    output in_ready, out_valid, result_out, exception, error
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential two's-complement ALU: single-cycle ops complete in one cycle,
// DIV/REM run a WIDTH-iteration restoring divider on magnitudes with a sign
// fixup on the last iteration. Results and flags are registered and held
// until the consumer accepts them.
module alu_seq #(
  parameter int WIDTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus,
  output logic [1:0] state_o
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_REM = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_MIN = 4'd10;
  localparam logic [3:0] OP_MAX = 4'd11;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             err_q;

  // Divider state: quo_q starts as the dividend magnitude and shifts the
  // quotient in from the bottom; rem_q is the partial remainder.
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [SHW-1:0]   cnt_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             is_rem_q;

  logic in_ready_w;
  logic accept;
  logic div_start;
  logic out_valid_w;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;

  assign a  = bus.a_in;
  assign b  = bus.b_in;
  assign op = bus.opcode;

  assign in_ready_w = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign accept     = bus.in_valid && in_ready_w;
  assign div_start  = accept && ((op == OP_DIV) || (op == OP_REM)) && (|b);

  // Single-cycle datapath pieces.
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   dif;
  logic [2*WIDTH-1:0] prod_full;
  logic               mul_ovf;
  logic               shift_big;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   sll_res;
  logic [WIDTH-1:0]   sra_res;
  logic               a_lt_b;

  assign sum       = a + b;
  assign dif       = a - b;
  assign prod_full = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  // The product fits iff the top WIDTH+1 bits are all copies of one sign bit.
  assign mul_ovf   = (|prod_full[2*WIDTH-1:WIDTH-1]) && !(&prod_full[2*WIDTH-1:WIDTH-1]);
  assign shift_big = |b[WIDTH-1:SHW];
  assign shamt     = b[SHW-1:0];
  assign sll_res   = shift_big ? '0 : (a << shamt);
  assign sra_res   = shift_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> shamt);
  assign a_lt_b    = $signed(a) < $signed(b);

  logic [WIDTH-1:0] sc_result;
  logic             sc_exc;
  logic             sc_err;

  // Result and flags for every op that completes in the accept cycle.
  always_comb begin
    sc_result = '0;
    sc_exc    = 1'b0;
    sc_err    = 1'b0;
    case (op)
      OP_ADD: begin
        sc_result = sum;
        sc_exc    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = dif;
        sc_exc    = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: begin
        sc_result = prod_full[WIDTH-1:0];
        sc_exc    = mul_ovf;
      end
      OP_DIV, OP_REM: sc_err = 1'b1;  // only reached with b == 0
      OP_AND: sc_result = a & b;
      OP_OR:  sc_result = a | b;
      OP_XOR: sc_result = a ^ b;
      OP_SLL: sc_result = sll_res;
      OP_SRA: sc_result = sra_res;
      OP_MIN: sc_result = a_lt_b ? a : b;
      OP_MAX: sc_result = a_lt_b ? b : a;
      default: sc_err = 1'b1;
    endcase
  end

  // One restoring-divider step plus the sign-corrected final values.
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    div_trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    if (div_trial[WIDTH]) begin
      rem_nx = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_nx = div_trial[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b1};
    end
    q_fix = q_neg_q ? (~quo_nx + 1'b1) : quo_nx;
    r_fix = r_neg_q ? (~rem_nx + 1'b1) : rem_nx;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    out_valid_w = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = div_start ? S_DIV : S_DONE;
      end
      S_DIV: begin
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_w = 1'b1;
        if (accept)             state_d = div_start ? S_DIV : S_DONE;
        else if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result/flag registers and divider iteration; reset aborts any divide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      exc_q    <= 1'b0;
      err_q    <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
    end else if (accept) begin
      if (div_start) begin
        // Magnitudes of the most-negative value come out as 2^(WIDTH-1),
        // which is exactly right when read as unsigned.
        quo_q    <= a[WIDTH-1] ? (~a + 1'b1) : a;
        dvs_q    <= b[WIDTH-1] ? (~b + 1'b1) : b;
        rem_q    <= '0;
        cnt_q    <= '0;
        q_neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
        r_neg_q  <= a[WIDTH-1];
        is_rem_q <= (op == OP_REM);
        exc_q    <= (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
        err_q    <= 1'b0;
      end else begin
        result_q <= sc_result;
        exc_q    <= sc_exc;
        err_q    <= sc_err;
      end
    end else if (state_q == S_DIV) begin
      quo_q <= quo_nx;
      rem_q <= rem_nx;
      cnt_q <= cnt_q + SHW'(1);
      if (cnt_q == CNT_LAST) result_q <= is_rem_q ? r_fix : q_fix;
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = out_valid_w;
  assign bus.result_out = result_q;
  assign bus.exception  = exc_q;
  assign bus.error      = err_q;
  assign state_o        = state_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Clocked, parametrised successor to the combinational ALU shell: two's-complement fixed-point operands instead of real values.
- Uses a valid/ready handshake on input and output, an iterative multi-cycle divider, and registered exception/error flags.
- Sits between an operand-issue stage and a result consumer; the result is held until the consumer accepts it.

Parameters:
WIDTH, 64, operand/result width in bits (>= 8, power of 2)
SHW, $clog2(WIDTH), localparam: shift-amount width taken from b_in[SHW-1:0]

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand/opcode presented
in_ready  output  1  block can accept an operation this cycle
a_in  input  WIDTH  operand A, signed
b_in  input  WIDTH  operand B, signed
opcode  input  4  operation select
out_valid  output  1  result_out/exception/error valid
out_ready  input  1  consumer accepts the result
result_out  output  WIDTH  registered result
exception  output  1  arithmetic overflow on this result
error  output  1  illegal opcode or divide-by-zero on this result

Behaviour:
- Reset (async, any state, including mid-divide): state=IDLE, divider aborted, out_valid=0, result_out=0, exception=0, error=0. in_ready=1 on the first edge after release.
- States:
  - IDLE: waiting for an operation.
  - DIV: iterating, count 0..WIDTH-1.
  - DONE: out_valid=1, outputs held stable until out_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Accept = in_valid && in_ready. Operands and opcode are captured at accept.
- Transitions:
  - Accept with a single-cycle op, from IDLE or DONE -> DONE. out_valid is high the next cycle (latency 1). Back-to-back throughput is 1 op/cycle while out_ready stays high.
  - Accept with DIV/REM and b!=0 -> DIV. The divider is a restoring divider on magnitudes, WIDTH iterations, with sign fixup on the final cycle. DONE is entered after WIDTH cycles, so out_valid is high WIDTH+1 cycles after accept.
  - DONE && out_ready && !accept -> IDLE, out_valid=0.
  - DONE && !out_ready -> stay in DONE; result_out, exception and error hold. in_valid is ignored.
- Opcodes (result modulo 2^WIDTH):
  - 0 ADD, 1 SUB: exception on signed overflow; result wraps.
  - 2 MUL: result is the low WIDTH bits; exception if the full signed product does not fit in WIDTH bits.
  - 3 DIV: quotient truncated toward zero.
  - 4 REM: remainder takes the sign of a.
  - 5 AND, 6 OR, 7 XOR.
  - 8 SLL by b[SHW-1:0]; if any b bit above SHW-1 is set, result=0.
  - 9 SRA by b[SHW-1:0]; if any b bit above SHW-1 is set, result is all sign bits.
  - 10 MIN, 11 MAX, signed.
  - 12-15 illegal: result=0, error=1, single-cycle.
- DIV/REM boundaries:
  - b==0: single-cycle, never enters DIV; result=0, error=1, exception=0.
  - a=most-negative, b=-1: exception=1; DIV result=most-negative, REM result=0. Still runs the iterative path.
- exception and error are cleared on every accepted op unless that op sets them. They are valid only with out_valid.
- An in_valid asserted during DIV is not accepted (in_ready=0). The requester must hold its values stable until accepted.

Test Plan:
- Reset then ADD a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> one cycle later out_valid=1, result=64'h8000_0000_0000_0000, exception=1, error=0.
- DIV a=-100, b=7 with out_ready=1 -> in_ready=0 for 64 cycles; out_valid exactly 65 cycles after accept with result=-14. REM with the same operands -> -2.
- DIV b=0 -> result=0, error=1 after 1 cycle. DIV a=64'h8000_0000_0000_0000, b=-1 -> result=64'h8000_0000_0000_0000, exception=1.
- Back-to-back stream of 5 single-cycle ops with out_ready=1 -> 5 consecutive out_valid cycles in order. Deassert out_ready for 3 cycles mid-stream -> result held, in_ready=0, no op lost.
- SLL a=1, b=63 -> 64'h8000_0000_0000_0000. SLL b=64 -> 0. SRA a=-8, b=2 -> -2. opcode=13 -> error=1, result=0.
- Assert rst 10 cycles into a DIV -> out_valid=0 and in_ready=1 after release. A fresh MUL a=3, b=-5 -> -15, exception=0.
